// File: rtl/guess_checker_if.sv
// Guess checker bus: round control, guess handshake and referee outputs.
// The master drives the round and the guesses; the slave is the referee.
interface guess_checker_if #(
  parameter int WIDTH = 4
) ();

  logic             Start;
  logic [WIDTH-1:0] Secret;
  logic             Guess_valid;
  logic [1:0]       Guess_player;
  logic [WIDTH-1:0] Guess;
  logic             Guess_ready;
  logic [1:0]       Correct_guess;
  logic [1:0]       Out_wr;
  logic [1:0]       Hint;

  modport master (
    output Start, Secret, Guess_valid, Guess_player, Guess,
    input  Guess_ready, Correct_guess, Out_wr, Hint
  );

  modport slave (
    input  Start, Secret, Guess_valid, Guess_player, Guess,
    output Guess_ready, Correct_guess, Out_wr, Hint
  );

endinterface

// File: rtl/guess_checker.sv
// Round referee for the guessing game.
// Latches the secret on Start, takes one guess at a time through a
// valid/ready handshake, evaluates it one cycle later, and reports the
// winner (Correct_guess) and the most recently eliminated player (Out_wr).
// Optional feature: define GUESS_HINT_EN to build the too-low/too-high
// Hint comparator; without it Hint is tied to 00.
module guess_checker #(
  parameter int WIDTH     = 4,
  parameter int MAX_TRIES = 3
) (
  input  logic           Clock,
  input  logic           Reset,
  guess_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] TRY_LIMIT = 4'(MAX_TRIES);

  state_t           state, state_n;
  logic [WIDTH-1:0] secret, secret_n;
  logic [WIDTH-1:0] guess_q, guess_n;
  logic [1:0]       player_q, player_n;
  logic [1:0]       correct_q, correct_n;
  logic [1:0]       out_wr_q, out_wr_n;
  logic [1:0]       hint_q, hint_n;
  // Indexed directly by player ID; entry 0 belongs to the invalid ID and stays 0.
  logic [3:0]       tries   [4];
  logic [3:0]       tries_n [4];
  logic [3:0]       elim, elim_n;

  // Register the FSM state and all round bookkeeping; reset clears everything.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      secret    <= '0;
      guess_q   <= '0;
      player_q  <= 2'b00;
      correct_q <= 2'b00;
      out_wr_q  <= 2'b00;
      hint_q    <= 2'b00;
      tries     <= '{default: 4'd0};
      elim      <= 4'b0000;
    end else begin
      state     <= state_n;
      secret    <= secret_n;
      guess_q   <= guess_n;
      player_q  <= player_n;
      correct_q <= correct_n;
      out_wr_q  <= out_wr_n;
      hint_q    <= hint_n;
      tries     <= tries_n;
      elim      <= elim_n;
    end
  end

  // Next-state logic: Start wins over everything, otherwise accept or judge a guess.
  always_comb begin
    state_n   = state;
    secret_n  = secret;
    guess_n   = guess_q;
    player_n  = player_q;
    correct_n = correct_q;
    out_wr_n  = out_wr_q;
    hint_n    = hint_q;
    tries_n   = tries;
    elim_n    = elim;

    if (bus.Start) begin
      secret_n  = bus.Secret;
      correct_n = 2'b00;
      out_wr_n  = 2'b00;
      hint_n    = 2'b00;
      tries_n   = '{default: 4'd0};
      elim_n    = 4'b0000;
      state_n   = ARMED;
    end else begin
      unique case (state)
        ARMED: begin
          if (bus.Guess_valid) begin
            player_n = bus.Guess_player;
            guess_n  = bus.Guess;
            state_n  = CHECK;
          end
        end
        CHECK: begin
          if (player_q == 2'b00 || elim[player_q]) begin
            state_n = ARMED;
          end else if (guess_q == secret) begin
            correct_n = player_q;
            hint_n    = 2'b00;
            state_n   = DONE;
          end else begin
            tries_n[player_q] = tries[player_q] + 4'd1;
`ifdef GUESS_HINT_EN
            hint_n = (guess_q < secret) ? 2'b01 : 2'b10;
`else
            hint_n = 2'b00;
`endif
            if (tries_n[player_q] == TRY_LIMIT) begin
              elim_n[player_q] = 1'b1;
              out_wr_n         = player_q;
            end
            state_n = (&elim_n[3:1]) ? DONE : ARMED;
          end
        end
        IDLE, DONE: begin
          state_n = state;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign bus.Guess_ready   = (state == ARMED);
  assign bus.Correct_guess = correct_q;
  assign bus.Out_wr        = out_wr_q;
  assign bus.Hint          = hint_q;

endmodule

// File: tb/tb_guess_checker.sv
// Testbench for guess_checker: directed rounds checked against a
// round-level behavioural model every cycle, plus hand-computed
// expectations at the interesting points of each round.
module tb_guess_checker;

  localparam int WIDTH     = 4;
  localparam int MAX_TRIES = 3;
`ifdef GUESS_HINT_EN
  localparam bit HINT_EN = 1'b1;
`else
  localparam bit HINT_EN = 1'b0;
`endif

  logic Clock;
  logic Reset;

  guess_checker_if #(.WIDTH(WIDTH)) bus ();

  guess_checker #(.WIDTH(WIDTH), .MAX_TRIES(MAX_TRIES)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Round model: an open round, at most one guess in flight, and a game-over flag.
  typedef struct packed {
    logic             open;
    logic             pending;
    logic             over;
    logic [WIDTH-1:0] secret;
    logic [1:0]       pPlayer;
    logic [WIDTH-1:0] pValue;
    logic [3:0][3:0]  tries;
    logic [3:0]       elim;
    logic [1:0]       correct;
    logic [1:0]       outWr;
    logic [1:0]       hint;
  } model_t;

  model_t m;
  bit     cmpEn = 1'b0;
  int     compared = 0;
  int     mismatched = 0;

  string      litName;
  logic [3:0] litMask;
  logic [1:0] litReady, litCorrect, litOutWr, litHint;
  int         litReq = 0;
  int         litSeen = 0;

  // Game rules applied once per clock to the sampled inputs.
  function automatic model_t modelNext(input model_t cur, input logic rst, input logic start,
                                       input logic [WIDTH-1:0] sec, input logic valid,
                                       input logic [1:0] player, input logic [WIDTH-1:0] value);
    model_t n;
    int p;
    n = cur;
    if (rst) begin
      n = '0;
    end else if (start) begin
      n = '0;
      n.open = 1'b1;
      n.secret = sec;
    end else if (cur.pending) begin
      n.pending = 1'b0;
      p = int'(cur.pPlayer);
      if (p != 0 && !cur.elim[p]) begin
        if (cur.pValue == cur.secret) begin
          n.correct = cur.pPlayer;
          n.hint = 2'b00;
          n.over = 1'b1;
        end else begin
          n.tries[p] = cur.tries[p] + 4'd1;
          n.hint = !HINT_EN ? 2'b00 : (cur.pValue < cur.secret) ? 2'b01 : 2'b10;
          if (int'(n.tries[p]) == MAX_TRIES) begin
            n.elim[p] = 1'b1;
            n.outWr = cur.pPlayer;
          end
          if (n.elim[1] && n.elim[2] && n.elim[3]) n.over = 1'b1;
        end
      end
    end else if (cur.open && !cur.over && valid) begin
      n.pending = 1'b1;
      n.pPlayer = player;
      n.pValue = value;
    end
    return n;
  endfunction

  // Advance the model on every rising edge using the inputs the DUT samples.
  initial begin
    m = '0;
    forever begin
      @(posedge Clock);
      m = modelNext(m, Reset, bus.Start, bus.Secret, bus.Guess_valid, bus.Guess_player, bus.Guess);
    end
  end

  task automatic compareOne(input string name, input logic [1:0] act, input logic [1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: model check every falling edge, plus any posted literal check.
  initial begin
    forever begin
      @(negedge Clock);
      if (cmpEn) begin
        compareOne("model_ready",   {1'b0, bus.Guess_ready}, {1'b0, m.open && !m.pending && !m.over});
        compareOne("model_correct", bus.Correct_guess, m.correct);
        compareOne("model_out_wr",  bus.Out_wr, m.outWr);
        compareOne("model_hint",    bus.Hint, m.hint);
      end
      if (litReq != litSeen) begin
        litSeen = litReq;
        if (litMask[3]) compareOne({litName, "_ready"},   {1'b0, bus.Guess_ready}, litReady);
        if (litMask[2]) compareOne({litName, "_correct"}, bus.Correct_guess, litCorrect);
        if (litMask[1]) compareOne({litName, "_out_wr"},  bus.Out_wr, litOutWr);
        if (litMask[0]) compareOne({litName, "_hint"},    bus.Hint, litHint);
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic start, input logic [WIDTH-1:0] sec,
                               input logic valid, input logic [1:0] player,
                               input logic [WIDTH-1:0] value);
    Reset            = rst;
    bus.Start        = start;
    bus.Secret       = sec;
    bus.Guess_valid  = valid;
    bus.Guess_player = player;
    bus.Guess        = value;
    @(posedge Clock);
    #1;
  endtask

  // Post a hand-computed expectation; mask bits are ready, correct, out_wr, hint.
  task automatic checkOutput(input string name, input logic [3:0] mask, input logic [1:0] r,
                             input logic [1:0] c, input logic [1:0] o, input logic [1:0] h);
    litName    = name;
    litMask    = mask;
    litReady   = r;
    litCorrect = c;
    litOutWr   = o;
    litHint    = h;
    litReq++;
    @(negedge Clock);
    #1;
  endtask

  initial begin
    $display("[TB] guess_checker bench start, HINT_EN=%0d", HINT_EN);
    applyStimulus(1, 0, 0, 0, 0, 0);
    cmpEn = 1'b1;
    checkOutput("lit_reset", 4'b1111, 0, 0, 0, 0);

    // Immediate win by player 01.
    applyStimulus(0, 1, 9, 0, 0, 0);
    checkOutput("lit_start_ready", 4'b1111, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 2'b01, 9);
    checkOutput("lit_check_busy", 4'b1000, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("lit_win_p1", 4'b1111, 0, 2'b01, 0, 0);
    applyStimulus(0, 0, 0, 1, 2'b10, 9);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("lit_done_hold", 4'b1110, 0, 2'b01, 0, 0);

    // Hints and elimination of player 10.
    applyStimulus(0, 1, 5, 0, 0, 0);
    checkOutput("lit_start_clear", 4'b1111, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 2'b10, 2);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("lit_hint_low", 4'b1111, 1, 0, 0, HINT_EN ? 2'b01 : 2'b00);
    applyStimulus(0, 0, 0, 1, 2'b10, 7);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("lit_hint_high", 4'b1111, 1, 0, 0, HINT_EN ? 2'b10 : 2'b00);
    applyStimulus(0, 0, 0, 1, 2'b10, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("lit_elim_p2", 4'b1111, 1, 0, 2'b10, HINT_EN ? 2'b01 : 2'b00);

    // Eliminated player and invalid player are ignored even with the right value.
    applyStimulus(0, 0, 0, 1, 2'b10, 5);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("lit_elim_ignored", 4'b1111, 1, 0, 2'b10, HINT_EN ? 2'b01 : 2'b00);
    applyStimulus(0, 0, 0, 1, 2'b00, 5);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("lit_p0_ignored", 4'b1110, 1, 0, 2'b10, 0);

    // Players 01 and 11 run out of tries: everyone is out.
    for (int i = 0; i < MAX_TRIES; i++) begin
      applyStimulus(0, 0, 0, 1, 2'b01, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
    end
    checkOutput("lit_elim_p1", 4'b1110, 1, 0, 2'b01, 0);
    for (int i = 0; i < MAX_TRIES; i++) begin
      applyStimulus(0, 0, 0, 1, 2'b11, 15);
      applyStimulus(0, 0, 0, 0, 0, 0);
    end
    checkOutput("lit_all_out", 4'b1111, 0, 0, 2'b11, HINT_EN ? 2'b10 : 2'b00);

    // Start beats a simultaneous guess, and Start during CHECK drops the guess.
    applyStimulus(0, 1, 3, 1, 2'b01, 3);
    applyStimulus(0, 1, 3, 1, 2'b01, 3);
    checkOutput("lit_start_beats_guess", 4'b1111, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 2'b01, 3);
    applyStimulus(0, 1, 3, 0, 0, 0);
    checkOutput("lit_start_in_check", 4'b1111, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 2'b11, 3);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("lit_win_p3", 4'b1111, 0, 2'b11, 0, 0);

    // Reset mid-round, guesses in IDLE, and Reset beating Start.
    applyStimulus(0, 1, 6, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 2'b01, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("lit_reset_armed", 4'b1111, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 2'b01, 6);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("lit_idle_ignore", 4'b1110, 0, 0, 0, 0);
    applyStimulus(1, 1, 7, 0, 0, 0);
    checkOutput("lit_reset_beats_start", 4'b1110, 0, 0, 0, 0);

    // Counters start from zero again in a fresh round.
    applyStimulus(0, 1, 6, 0, 0, 0);
    for (int i = 0; i < MAX_TRIES - 1; i++) begin
      applyStimulus(0, 0, 0, 1, 2'b01, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
    end
    checkOutput("lit_tries_cleared", 4'b1110, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 2'b01, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("lit_p1_last_try", 4'b1110, 1, 0, 2'b01, 0);

    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge Clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/guess_checker.md
# guess_checker

Round referee for the guessing game. Latches a secret number at round start, accepts player guesses through a valid/ready handshake, and tracks per-player attempts. Drives the 2-bit `Correct_guess` (winning player) and `Out_wr` (most recently eliminated player) codes that the `Decision` stage turns into the game `Result`.

## Interface
- `WIDTH`, default 4: bit width of the secret and the guesses.
- `MAX_TRIES`, default 3: wrong guesses allowed per player before elimination; legal range 1..15.
- `Clock`  in  1  system clock, rising edge.
- `Reset`  in  1  synchronous, active-high reset; overrides every other input.
- `Start`  in  1  one-cycle pulse: load `Secret`, clear round state, open the round.
- `Secret`  in  WIDTH  secret value; sampled only on `Start`.
- `Guess_valid`  in  1  a guess is presented.
- `Guess_player`  in  2  guessing player: 01, 10, 11; 00 is invalid.
- `Guess`  in  WIDTH  guessed value.
- `Guess_ready`  out  1  checker accepts a guess this cycle.
- `Correct_guess`  out  2  winner ID; 00 while there is no winner.
- `Out_wr`  out  2  ID of the most recently eliminated player; 00 while nobody is eliminated.
- `Hint`  out  2  01 = last guess too low, 10 = too high, 00 = none or equal.

## Operation
- States: IDLE, ARMED, CHECK, DONE. Reset enters IDLE.
- Reset sets every output and internal register to 0: `Guess_ready`=0, `Correct_guess`=00, `Out_wr`=00, `Hint`=00, all try counters 0, secret register 0.
- `Start` is honoured in any state: secret register <= `Secret`; counters, eliminated flags and outputs are cleared; next state is ARMED. `Start` while in CHECK discards the pending guess.
- ARMED: `Guess_ready`=1. On `Guess_valid && Guess_ready`, register the player and the guess, then go to CHECK.
- CHECK (one cycle), evaluated in this priority order:
  - Player 00, or a player that is already eliminated: discard the guess. No counter or output change. Return to ARMED.
  - Guess equals the secret: `Correct_guess` <= player, `Hint` <= 00. Go to DONE.
  - Otherwise: increment that player's counter and set `Hint` to 01 or 10. If the counter reaches `MAX_TRIES`, mark the player eliminated and set `Out_wr` <= player. If all three players are now eliminated, go to DONE; otherwise return to ARMED.
- DONE: `Guess_ready`=0. All outputs hold until `Start` or `Reset`.
- IDLE: `Guess_ready`=0 and guesses are ignored.
- Comparison is unsigned and WIDTH bits wide. Counters are 4-bit and never exceed `MAX_TRIES`.
- `Correct_guess` and `Out_wr` can both be non-zero at the same time. The downstream stage gives the winner priority.

## Timing
- Handshake completes at rising edge k. Outputs update at edge k+1.
- `Guess_ready` is low during CHECK, so the maximum throughput is one guess per 2 cycles.
- `Start` at edge k: `Guess_ready`=1 from edge k onward, with cleared outputs visible after edge k.
- `Reset` and `Start` in the same cycle: reset wins, and the next state is IDLE.
- `Guess_valid` together with `Start`: the guess is not accepted, because `Guess_ready` reflects the pre-`Start` state only if that state was ARMED, and `Start` has priority.
- All outputs are registered. No output has a combinational path from any input.

## Configuration
- `GUESS_HINT_EN` defined: `Hint` behaves as described in Operation.
- `GUESS_HINT_EN` undefined: the comparison logic for the hint is not built and `Hint` is constant 00. The port remains present. All other behaviour is identical.

## Test plan
- Reset, then Start with `Secret`=9. Player 01 guesses 9 → after 2 cycles `Correct_guess`=01, `Out_wr`=00, `Guess_ready`=0, state DONE.
- `Secret`=5. Player 10 guesses 2 → `Hint`=01. Player 10 guesses 7 → `Hint`=10. Player 10 guesses 1 → `Out_wr`=10, and `Guess_ready` returns to 1.
- With `MAX_TRIES`=3, players 01, 10 and 11 each guess wrong 3 times → `Out_wr`=11 after the last check, `Correct_guess`=00, state DONE.
- Eliminated player 10 guesses the secret → no output change. `Guess_player`=00 with a correct guess → ignored.
- `Start` asserted during CHECK with `Secret`=3 → pending guess dropped, outputs cleared, `Guess_ready`=1. A new guess of 3 from player 11 → `Correct_guess`=11.
- `Reset` during ARMED with counters non-zero → next cycle all outputs 0 and `Guess_ready`=0. A guess while in IDLE is not accepted.
